// File: rtl/dram_arbiter.sv
// Two-requester (CPU / loader) arbiter for port A of the shared data RAM, with burst locking.
// Define DRAM_ARB_STARVE_EN to add the loader starvation counter and forced grant.
module dram_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_lock,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  input  logic          l_req,
  input  logic          l_lock,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   c_rvalid_q, l_rvalid_q;
  logic   c_win, l_win;
  logic   owner_held;
  logic   starve;

`ifdef DRAM_ARB_STARVE_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign starve = (starve_cnt_q == 8'(STARVE_MAX));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!l_req || l_gnt) begin
      starve_cnt_d = 8'd0;
    end else if (!starve) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // A locked owner keeps the port even while idle; otherwise fall back to the open rules.
  assign owner_held = ((owner_q == OWN_CPU) && c_lock) || ((owner_q == OWN_LDR) && l_lock);

  always_comb begin
    c_win = 1'b0;
    l_win = 1'b0;
    if ((owner_q == OWN_CPU) && c_lock) begin
      c_win = c_req;
    end else if ((owner_q == OWN_LDR) && l_lock) begin
      l_win = l_req;
    end else if (starve && l_req) begin
      l_win = 1'b1;
    end else if (c_req) begin
      c_win = 1'b1;
    end else if (l_req) begin
      l_win = 1'b1;
    end
  end

  // Grants are masked by reset so mem_we drops the instant reset asserts.
  assign c_gnt = c_win & reset;
  assign l_gnt = l_win & reset;

  always_comb begin
    owner_d = OWN_NONE;
    if (c_gnt) begin
      owner_d = c_lock ? OWN_CPU : OWN_NONE;
    end else if (l_gnt) begin
      owner_d = l_lock ? OWN_LDR : OWN_NONE;
    end else if (owner_held) begin
      owner_d = owner_q;
    end
  end

  assign mem_addr  = l_win ? l_addr  : c_addr;
  assign mem_wdata = l_win ? l_wdata : c_wdata;
  assign mem_we    = (c_gnt & c_we) | (l_gnt & l_we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      c_rvalid_q <= c_gnt & ~c_we;
      l_rvalid_q <= l_gnt & ~l_we;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign rdata    = mem_q;
  assign busy     = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural 4K x 32 RAM on port A.
// Expectations track DRAM_ARB_STARVE_EN, so the bench works with or without the macro.
module tb_dram_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_lock, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt, c_rvalid;
  logic          l_req, l_lock, l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt, l_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic          busy;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_lock(c_lock), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_q(mem_q), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  initial begin
    reset = 1'b0;
    c_req = 1'b1; c_lock = 1'b0; c_we = 1'b1; c_addr = 12'h010; c_wdata = 32'hDEADBEEF;
    l_req = 1'b1; l_lock = 1'b0; l_we = 1'b0; l_addr = 12'h020; l_wdata = 32'h0;

    // Reset held with both requests high
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_c_gnt",    32'(c_gnt),    32'd0);
    check_eq("rst_l_gnt",    32'(l_gnt),    32'd0);
    check_eq("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    check_eq("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    check_eq("rst_mem_we",   32'(mem_we),   32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);

    // Release: CPU wins immediately and preloads 0x010 with DEADBEEF
    @(negedge clk); reset = 1'b1;
    #1;
    check_eq("rel_c_gnt",    32'(c_gnt),    32'd1);
    check_eq("rel_l_gnt",    32'(l_gnt),    32'd0);
    check_eq("rel_mem_we",   32'(mem_we),   32'd1);
    check_eq("rel_mem_addr", 32'(mem_addr), 32'h010);

    @(negedge clk); c_req = 1'b0; l_req = 1'b0;
    #1;
    check_eq("wr_no_rvalid", 32'(c_rvalid), 32'd0);
    check_eq("idle_mem_we",  32'(mem_we),   32'd0);

    // Single loader read
    @(negedge clk); l_req = 1'b1; l_we = 1'b0; l_addr = 12'h010;
    #1;
    check_eq("rd_l_gnt",    32'(l_gnt),    32'd1);
    check_eq("rd_c_gnt",    32'(c_gnt),    32'd0);
    check_eq("rd_mem_addr", 32'(mem_addr), 32'h010);
    @(negedge clk); l_req = 1'b0;
    #1;
    check_eq("rd_l_rvalid", 32'(l_rvalid), 32'd1);
    check_eq("rd_rdata",    rdata,         32'hDEADBEEF);
    check_eq("rd_c_rvalid", 32'(c_rvalid), 32'd0);

    // Contention with locks low
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010; c_lock = 1'b0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 12'h010; l_lock = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("cont_c_gnt_%0d", i), 32'(c_gnt), 32'd1);
      check_eq($sformatf("cont_l_gnt_%0d", i), 32'(l_gnt), 32'd0);
      if (i == 1) check_eq("cont_c_rdata", rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    #1;
`ifdef DRAM_ARB_STARVE_EN
    check_eq("cont9_l_gnt", 32'(l_gnt), 32'd1);
    check_eq("cont9_c_gnt", 32'(c_gnt), 32'd0);
`else
    check_eq("cont9_l_gnt", 32'(l_gnt), 32'd0);
    check_eq("cont9_c_gnt", 32'(c_gnt), 32'd1);
`endif
    @(negedge clk); c_req = 1'b0; l_req = 1'b0;
    #1;
`ifdef DRAM_ARB_STARVE_EN
    check_eq("cont9_l_rvalid", 32'(l_rvalid), 32'd1);
`else
    check_eq("cont9_c_rvalid", 32'(c_rvalid), 32'd1);
`endif

    // CPU takes a lock, idles locked while the loader starves, then bursts 4 writes
    @(negedge clk); c_req = 1'b1; c_lock = 1'b1; c_we = 1'b1; c_addr = 12'h0FE; c_wdata = 32'h0;
    #1;
    check_eq("lock_c_gnt", 32'(c_gnt), 32'd1);
    @(negedge clk); c_req = 1'b0; l_req = 1'b1; l_lock = 1'b0; l_we = 1'b0; l_addr = 12'h010;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 0 || i == 7) begin
        check_eq($sformatf("lidle_l_gnt_%0d", i), 32'(l_gnt), 32'd0);
        check_eq($sformatf("lidle_busy_%0d", i),  32'(busy),  32'd1);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      c_req = 1'b1; c_we = 1'b1; c_addr = 12'(12'h100 + k); c_wdata = 32'hA0000000 + 32'(k);
      #1;
      check_eq($sformatf("burst_c_gnt_%0d", k),  32'(c_gnt),    32'd1);
      check_eq($sformatf("burst_l_gnt_%0d", k),  32'(l_gnt),    32'd0);
      check_eq($sformatf("burst_we_%0d", k),     32'(mem_we),   32'd1);
      check_eq($sformatf("burst_addr_%0d", k),   32'(mem_addr), 32'h100 + 32'(k));
      @(negedge clk);
    end
    c_req = 1'b0; c_lock = 1'b0;
    #1;
    check_eq("unlock_l_gnt", 32'(l_gnt), 32'd1);
    check_eq("unlock_c_gnt", 32'(c_gnt), 32'd0);
    @(negedge clk); l_req = 1'b0;
    #1;
    check_eq("unlock_l_rvalid", 32'(l_rvalid), 32'd1);
    check_eq("unlock_rdata",    rdata,         32'hDEADBEEF);
    check_eq("unlock_busy",     32'(busy),     32'd0);

    // Read back one burst word
    @(negedge clk); c_req = 1'b1; c_we = 1'b0; c_addr = 12'h102;
    #1;
    check_eq("rb_c_gnt", 32'(c_gnt), 32'd1);
    @(negedge clk); c_req = 1'b0;
    #1;
    check_eq("rb_rdata", rdata, 32'hA0000002);

    // Loader locks, idles with lock high while the CPU requests
    @(negedge clk); l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 12'h200; l_wdata = 32'h55;
    #1;
    check_eq("llock_l_gnt", 32'(l_gnt),    32'd1);
    check_eq("llock_addr",  32'(mem_addr), 32'h200);
    @(negedge clk); l_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 12'h102;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("lidle_c_gnt_%0d", i), 32'(c_gnt),  32'd0);
      check_eq($sformatf("lidle_we_%0d", i),    32'(mem_we), 32'd0);
      check_eq($sformatf("lidle_busyl_%0d", i), 32'(busy),   32'd1);
      @(negedge clk);
    end
    l_lock = 1'b0;
    #1;
    check_eq("lrel_c_gnt", 32'(c_gnt),    32'd1);
    check_eq("lrel_addr",  32'(mem_addr), 32'h102);
    @(negedge clk); c_req = 1'b0;
    #1;
    check_eq("lrel_rdata", rdata,     32'hA0000002);
    check_eq("lrel_busy",  32'(busy), 32'd0);

    // Reset pulse between a loader read grant and its capture edge
    @(negedge clk); l_req = 1'b1; l_lock = 1'b1; l_we = 1'b0; l_addr = 12'h010;
    #1;
    check_eq("mrst_l_gnt", 32'(l_gnt), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mrst_gnt_drop", 32'(l_gnt),  32'd0);
    check_eq("mrst_we_drop",  32'(mem_we), 32'd0);
    @(negedge clk); l_req = 1'b0; l_lock = 1'b0; reset = 1'b1;
    #1;
    check_eq("mrst_l_rvalid", 32'(l_rvalid), 32'd0);
    check_eq("mrst_busy",     32'(busy),     32'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
